// File: rtl/data_memory_dumper_pkg.sv
// Shared debug definitions: byte width, dumper state encoding, bytes per data word.
// Used by the dumper, the UART transmitter and the debug unit.
package data_memory_dumper_pkg;

    localparam int DBG_NB_BYTE    = 8;
    localparam int DBG_NB_DATA    = 32;
    localparam int BYTES_PER_WORD = DBG_NB_DATA / DBG_NB_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LOAD = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_memory_dumper_word_serializer.sv
// Splits one data word into bytes, MSB first, over a valid/ready byte port.
// Load presents the first byte next cycle; each stalled cycle holds the current byte.
module word_serializer
    import data_memory_dumper_pkg::*;
#(
    parameter int NB_DATA = DBG_NB_DATA,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_i,
    input  logic               tx_ready_i,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_valid_o,
    output logic               last_byte_accepted_o
);

    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = cnt_width(BPW);
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               xfer;

    assign xfer                 = valid_q && tx_ready_i;
    assign last_byte_accepted_o = xfer && (cnt_q == LAST_CNT);
    assign tx_data_o            = shift_q[NB_DATA-1 -: NB_BYTE];
    assign tx_valid_o           = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (cnt_q == LAST_CNT) begin
                valid_d = 1'b0;
            end else begin
                // The next byte always sits at the top of the register.
                shift_d = shift_q << NB_BYTE;
                cnt_d   = cnt_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/data_memory_dumper.sv
// Drains data memory words 0..last_addr to the UART as big-endian bytes on a debug start.
// Six cycles per word without backpressure; each ready-low byte cycle adds one.
module data_memory_dumper
    import data_memory_dumper_pkg::*;
#(
    parameter int NB_DATA = DBG_NB_DATA,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = DBG_NB_BYTE
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_last_addr,
    output logic               o_mem_rd_en,
    output logic [NB_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] word_cnt_q;
    logic [NB_ADDR-1:0] last_addr_q;
    logic               rd_en_q;
    logic               busy_q;
    logic               done_q;
    logic               last_byte_accepted;
    logic               last_word;

    // Compared before incrementing so a full-depth dump ends instead of wrapping.
    assign last_word = (word_cnt_q == last_addr_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_READ;
            ST_READ: state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (last_byte_accepted) begin
                    state_d = last_word ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            last_addr_q <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= (state_d == ST_READ);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && i_start) begin
                last_addr_q <= i_last_addr;
                word_cnt_q  <= '0;
            end else if (state_q == ST_SEND && last_byte_accepted && !last_word) begin
                word_cnt_q <= word_cnt_q + NB_ADDR'(1);
            end
        end
    end

    assign o_mem_rd_en = rd_en_q;
    assign o_mem_addr  = word_cnt_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_serializer (
        .clk_i                (i_clock),
        .rst_i                (i_reset),
        .load_i               (state_q == ST_LOAD),
        .word_i               (i_mem_data),
        .tx_ready_i           (i_tx_ready),
        .tx_data_o            (o_tx_data),
        .tx_valid_o           (o_tx_valid),
        .last_byte_accepted_o (last_byte_accepted)
    );

endmodule

// File: tb/tb_data_memory_dumper.sv
// Randomized bench for data_memory_dumper against a byte-queue and cycle-count reference.
module tb_data_memory_dumper;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_BYTE = 8;
    localparam int DEPTH   = 1 << NB_ADDR;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [NB_ADDR-1:0] last_addr;
    logic               mem_rd_en;
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_DATA-1:0] mem_rdata;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               done;

    logic [NB_DATA-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_dumper #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR),
        .NB_BYTE (NB_BYTE)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_last_addr (last_addr),
        .o_mem_rd_en (mem_rd_en),
        .o_mem_addr  (mem_addr),
        .i_mem_data  (mem_rdata),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Synchronous-read data memory debug port.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_addr"},  32'(mem_addr),  0);
        check({tag, "_data"},  32'(tx_data),   0);
        check({tag, "_valid"}, 32'(tx_valid),  0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_done"},  32'(done),      0);
    endtask

    // One full dump: expected bytes come from the memory image, expected
    // completion from 6 cycles per word plus one per stalled byte cycle.
    task automatic run_dump(input int last, input int ready_pct, input bit mid_start);
        logic [7:0] exp_q[$];
        logic [NB_DATA-1:0] w;
        logic [7:0] held;
        bit hold = 0;
        bit done_seen = 0;
        int n = last + 1;
        int stalls = 0;
        int exp_addr = 0;
        int cyc;
        for (int i = 0; i < n; i++) begin
            w = mem[i];
            for (int b = 0; b < 4; b++) exp_q.push_back(w[31 - 8*b -: 8]);
        end
        start     = 1'b1;
        last_addr = NB_ADDR'(last);
        tick();
        cyc = 1;
        while (!done_seen && cyc < 4000) begin
            tx_ready = ($urandom_range(99) < ready_pct);
            if (mid_start && cyc == 10) begin
                start     = 1'b1;
                last_addr = NB_ADDR'(last + 7);
            end else begin
                start = 1'b0;
            end
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_addr), exp_addr);
                exp_addr++;
            end
            if (tx_valid) begin
                if (hold) check("tx_hold", 32'(tx_data), 32'(held));
                if (tx_ready) begin
                    if (exp_q.size() == 0) check("extra_byte", 1, 0);
                    else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    hold = 0;
                end else begin
                    stalls++;
                    hold = 1;
                    held = tx_data;
                end
            end
            if (done) begin
                done_seen = 1;
                check("done_cycle", cyc, 6*n + 1 + stalls);
                check("bytes_left", exp_q.size(), 0);
                check("read_count", exp_addr, n);
            end else begin
                check("busy", 32'(busy), 1);
            end
            tick();
            cyc++;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        if (!done_seen) check("timeout", 0, 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        last_addr = '0;
        tx_ready  = 1'b1;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h00000000;
        mem[3] = 32'hFFFFFFFF;
        for (int i = 4; i < DEPTH; i++) mem[i] = $urandom;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_dump(3, 100, 0);
        run_dump(0, 100, 0);
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        run_dump(DEPTH - 1, 100, 0);
        run_dump(5, 60, 0);
        run_dump(2, 50, 1);

        // Reset while word 1 is being sent, then restart from address 0.
        start     = 1'b1;
        last_addr = NB_ADDR'(3);
        tx_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("pre_reset_valid", 32'(tx_valid), 1);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("post_reset_done", 32'(done), 0);
            check("post_reset_valid", 32'(tx_valid), 0);
            check("post_reset_busy", 32'(busy), 0);
        end
        run_dump(3, 70, 0);
        run_dump(1, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
